// File: rtl/shift_link_pkg.sv
// Shared definitions for the serial shift-register link: FSM encoding,
// frame direction constants and transmitter mode codes.
package shift_link_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  localparam logic DIR_LSB_FIRST = 1'b0;
  localparam logic DIR_MSB_FIRST = 1'b1;

  // Mode codes of the matching bidirectional transmitter.
  typedef enum logic [1:0] {
    HOLD    = 2'b00,
    SHIFT_R = 2'b01,
    SHIFT_L = 2'b10,
    LOAD    = 2'b11
  } tx_mode_t;

endpackage

// File: rtl/shift_frame_outreg.sv
// One-entry valid/ready holding register for assembled words.
// A load always wins over a consume on the same edge.
module shift_frame_outreg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             dout_ready,
  output logic             can_load,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid
);

  assign can_load = !dout_valid || dout_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (load) begin
      dout       <= load_data;
      dout_valid <= 1'b1;
    end else if (dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/shift_frame_deserializer.sv
// Serial-to-parallel receiver: assembles WIDTH-bit frames MSB- or LSB-first
// and hands them to a valid/ready consumer, stalling the serial side when full.
module shift_frame_deserializer
  import shift_link_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  input  logic             sin_valid,
  output logic             sin_ready,
  input  logic             msb_first,
  input  logic             clear,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [CW-1:0]    bit_cnt,
  output logic             overrun
);

  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt, shreg_shift;
  logic [CW-1:0]    cnt_nxt;
  logic             dir, dir_nxt, ovr_nxt;
  logic             eff_dir, load, can_load;
  logic [WIDTH-1:0] load_data;

  assign sin_ready = (state != ST_STALL);

  // The first bit of a frame shifts with the live direction input.
  assign eff_dir     = (bit_cnt == '0) ? msb_first : dir;
  assign shreg_shift = eff_dir ? {shreg[WIDTH-2:0], sin} : {sin, shreg[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      dir     <= DIR_MSB_FIRST;
      overrun <= 1'b0;
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      bit_cnt <= cnt_nxt;
      dir     <= dir_nxt;
      overrun <= ovr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = bit_cnt;
    dir_nxt   = dir;
    ovr_nxt   = overrun;
    load      = 1'b0;
    load_data = shreg_shift;
    if (clear) begin
      state_nxt = ST_IDLE;
      shreg_nxt = '0;
      cnt_nxt   = '0;
      ovr_nxt   = 1'b0;
    end else begin
      if (sin_valid && !sin_ready) ovr_nxt = 1'b1;
      case (state)
        ST_STALL: begin
          if (dout_ready) begin
            load      = 1'b1;
            load_data = shreg;
            state_nxt = ST_IDLE;
            shreg_nxt = '0;
            cnt_nxt   = '0;
          end
        end
        default: begin
          if (sin_valid) begin
            if (bit_cnt == '0) dir_nxt = msb_first;
            if (bit_cnt == LAST_CNT) begin
              if (can_load) begin
                load      = 1'b1;
                state_nxt = ST_IDLE;
                shreg_nxt = '0;
                cnt_nxt   = '0;
              end else begin
                state_nxt = ST_STALL;
                shreg_nxt = shreg_shift;
                cnt_nxt   = FULL_CNT;
              end
            end else begin
              state_nxt = ST_SHIFT;
              shreg_nxt = shreg_shift;
              cnt_nxt   = bit_cnt + CW'(1);
            end
          end
        end
      endcase
    end
  end

  shift_frame_outreg #(.WIDTH(WIDTH)) u_outreg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .load_data  (load_data),
    .dout_ready (dout_ready),
    .can_load   (can_load),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

endmodule

// File: tb/tb_shift_frame_deserializer.sv
// Scenario bench for shift_frame_deserializer with a queue of expected words.
module tb_shift_frame_deserializer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sin, sin_valid, sin_ready, msb_first, clear;
  logic [3:0] dout;
  logic       dout_valid, dout_ready;
  logic [2:0] bit_cnt;
  logic       overrun;

  int checks = 0;
  int errors = 0;
  logic [3:0] sb[$];
  logic [3:0] exp_w;

  shift_frame_deserializer #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .sin_ready  (sin_ready),
    .msb_first  (msb_first),
    .clear      (clear),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .bit_cnt    (bit_cnt),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // seq[3] is the first bit on the wire.
  function automatic logic [3:0] mk_word(input logic [3:0] seq, input logic msb);
    if (msb) return seq;
    return {seq[0], seq[1], seq[2], seq[3]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    sin       = b;
    sin_valid = 1'b1;
    tick();
    sin_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sin = 0; sin_valid = 0; msb_first = 1; clear = 0; dout_ready = 0;
    #12 rst_n = 1'b1;
    tick();
    checks++; if (dout !== 4'b0)   begin errors++; $display("FAIL reset_dout got %b want 0000", dout); end
    checks++; if (dout_valid !== 0) begin errors++; $display("FAIL reset_valid got %b want 0", dout_valid); end
    checks++; if (bit_cnt !== 0)   begin errors++; $display("FAIL reset_cnt got %0d want 0", bit_cnt); end
    checks++; if (sin_ready !== 1) begin errors++; $display("FAIL reset_ready got %b want 1", sin_ready); end
    checks++; if (overrun !== 0)   begin errors++; $display("FAIL reset_ovr got %b want 0", overrun); end
  endtask

  task automatic test_msb_first();
    dout_ready = 1; msb_first = 1;
    sb.push_back(mk_word(4'b1011, 1'b1));
    send_bit(1); send_bit(0); send_bit(1);
    checks++; if (bit_cnt !== 3) begin errors++; $display("FAIL msb_cnt3 got %0d want 3", bit_cnt); end
    send_bit(1);
    exp_w = sb.pop_front();
    checks++; if (dout_valid !== 1) begin errors++; $display("FAIL msb_valid got %b want 1", dout_valid); end
    checks++; if (dout !== exp_w)   begin errors++; $display("FAIL msb_word got %b want %b", dout, exp_w); end
    checks++; if (bit_cnt !== 0)    begin errors++; $display("FAIL msb_cnt0 got %0d want 0", bit_cnt); end
    tick();
    checks++; if (dout_valid !== 0) begin errors++; $display("FAIL msb_consumed got %b want 0", dout_valid); end
  endtask

  task automatic test_lsb_first();
    dout_ready = 1; msb_first = 0;
    sb.push_back(mk_word(4'b1011, 1'b0));
    send_bit(1);
    msb_first = 1;
    send_bit(0); send_bit(1); send_bit(1);
    exp_w = sb.pop_front();
    checks++; if (dout_valid !== 1) begin errors++; $display("FAIL lsb_valid got %b want 1", dout_valid); end
    checks++; if (dout !== exp_w)   begin errors++; $display("FAIL lsb_word got %b want %b", dout, exp_w); end
    tick();
  endtask

  task automatic test_stall_overrun();
    logic [3:0] held;
    dout_ready = 0; msb_first = 1;
    sb.push_back(mk_word(4'b1100, 1'b1));
    send_bit(1); send_bit(1); send_bit(0); send_bit(0);
    held = sb.pop_front();
    checks++; if (dout !== held) begin errors++; $display("FAIL stall_first got %b want %b", dout, held); end
    sb.push_back(mk_word(4'b0110, 1'b1));
    send_bit(0); send_bit(1); send_bit(1); send_bit(0);
    checks++; if (sin_ready !== 0) begin errors++; $display("FAIL stall_ready got %b want 0", sin_ready); end
    checks++; if (bit_cnt !== 4)   begin errors++; $display("FAIL stall_cnt got %0d want 4", bit_cnt); end
    checks++; if (dout !== held || dout_valid !== 1)
      begin errors++; $display("FAIL stall_hold got %b/%b want %b/1", dout, dout_valid, held); end
    send_bit(1);
    checks++; if (overrun !== 1) begin errors++; $display("FAIL ovr_set got %b want 1", overrun); end
    checks++; if (bit_cnt !== 4) begin errors++; $display("FAIL ovr_cnt got %0d want 4", bit_cnt); end
    dout_ready = 1;
    tick();
    exp_w = sb.pop_front();
    checks++; if (dout !== exp_w)   begin errors++; $display("FAIL stall_release got %b want %b", dout, exp_w); end
    checks++; if (dout_valid !== 1) begin errors++; $display("FAIL stall_rel_valid got %b want 1", dout_valid); end
    checks++; if (sin_ready !== 1)  begin errors++; $display("FAIL stall_rel_ready got %b want 1", sin_ready); end
    checks++; if (bit_cnt !== 0)    begin errors++; $display("FAIL stall_rel_cnt got %0d want 0", bit_cnt); end
    tick();
    checks++; if (dout_valid !== 0) begin errors++; $display("FAIL stall_drain got %b want 0", dout_valid); end
  endtask

  task automatic test_gapped();
    logic [7:0] bits;
    bits = 8'b10010111;
    dout_ready = 1; msb_first = 1;
    sb.push_back(mk_word(bits[7:4], 1'b1));
    sb.push_back(mk_word(bits[3:0], 1'b1));
    for (int i = 0; i < 8; i++) begin
      send_bit(bits[7-i]);
      if (i == 3 || i == 7) begin
        exp_w = sb.pop_front();
        checks++; if (dout_valid !== 1 || dout !== exp_w)
          begin errors++; $display("FAIL gap_word%0d got %b/%b want %b/1", i, dout, dout_valid, exp_w); end
      end
      tick();
      checks++; if (dout_valid !== 0) begin errors++; $display("FAIL gap_idle%0d got %b want 0", i, dout_valid); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bits;
    bits = 8'b01101010;
    dout_ready = 1; msb_first = 0;
    sb.push_back(mk_word(bits[7:4], 1'b0));
    sb.push_back(mk_word(bits[3:0], 1'b0));
    for (int i = 0; i < 8; i++) begin
      send_bit(bits[7-i]);
      if (i == 3 || i == 7) begin
        exp_w = sb.pop_front();
        checks++; if (dout_valid !== 1 || dout !== exp_w)
          begin errors++; $display("FAIL b2b_word%0d got %b/%b want %b/1", i, dout, dout_valid, exp_w); end
      end else if (i == 4) begin
        checks++; if (dout_valid !== 0) begin errors++; $display("FAIL b2b_drop got %b want 0", dout_valid); end
      end
    end
    tick();
  endtask

  task automatic test_clear();
    logic [3:0] hd;
    logic       hv;
    checks++; if (overrun !== 1) begin errors++; $display("FAIL ovr_sticky got %b want 1", overrun); end
    dout_ready = 1; msb_first = 1;
    send_bit(1); send_bit(1);
    checks++; if (bit_cnt !== 2) begin errors++; $display("FAIL clr_pre_cnt got %0d want 2", bit_cnt); end
    hd = dout; hv = dout_valid;
    clear = 1; sin = 1; sin_valid = 1;
    tick();
    clear = 0; sin_valid = 0;
    checks++; if (bit_cnt !== 0) begin errors++; $display("FAIL clr_cnt got %0d want 0", bit_cnt); end
    checks++; if (overrun !== 0) begin errors++; $display("FAIL clr_ovr got %b want 0", overrun); end
    checks++; if (dout !== hd || dout_valid !== hv)
      begin errors++; $display("FAIL clr_dout got %b/%b want %b/%b", dout, dout_valid, hd, hv); end
    sb.push_back(mk_word(4'b0001, 1'b1));
    send_bit(0); send_bit(0); send_bit(0); send_bit(1);
    exp_w = sb.pop_front();
    checks++; if (dout_valid !== 1 || dout !== exp_w)
      begin errors++; $display("FAIL clr_next got %b/%b want %b/1", dout, dout_valid, exp_w); end
    tick();
  endtask

  task automatic test_async_reset();
    dout_ready = 0; msb_first = 1;
    sb.push_back(mk_word(4'b1100, 1'b1));
    send_bit(1); send_bit(1); send_bit(0); send_bit(0);
    exp_w = sb.pop_front();
    checks++; if (dout !== exp_w) begin errors++; $display("FAIL ar_first got %b want %b", dout, exp_w); end
    send_bit(0); send_bit(1); send_bit(1); send_bit(0);
    checks++; if (sin_ready !== 0) begin errors++; $display("FAIL ar_stall got %b want 0", sin_ready); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (dout !== 4'b0)    begin errors++; $display("FAIL ar_dout got %b want 0000", dout); end
    checks++; if (dout_valid !== 0) begin errors++; $display("FAIL ar_valid got %b want 0", dout_valid); end
    checks++; if (sin_ready !== 1)  begin errors++; $display("FAIL ar_ready got %b want 1", sin_ready); end
    checks++; if (bit_cnt !== 0)    begin errors++; $display("FAIL ar_cnt got %0d want 0", bit_cnt); end
    #3 rst_n = 1'b1;
    dout_ready = 1;
    tick();
    sb.push_back(mk_word(4'b1010, 1'b1));
    send_bit(1); send_bit(0); send_bit(1); send_bit(0);
    exp_w = sb.pop_front();
    checks++; if (dout_valid !== 1 || dout !== exp_w)
      begin errors++; $display("FAIL ar_after got %b/%b want %b/1", dout, dout_valid, exp_w); end
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_stall_overrun();
    test_gapped();
    test_back_to_back();
    test_clear();
    test_async_reset();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_empty got %0d want 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_frame_deserializer.md
Name: shift_frame_deserializer

Overview:
- Receive end of the team's serial shift-register link: takes a bit stream driven by a bidirectional shift register and reassembles it into WIDTH-bit parallel words.
- Handles both shift directions (MSB-first / LSB-first), selected per frame.
- Presents each completed word on a valid/ready output port, with input backpressure and sticky overrun detection.
- Sits between the serial pins of a shift-register stage and a parallel consumer.

Parameters:
- WIDTH, 4, word width in bits; legal range ≥2.
- CW, $clog2(WIDTH+1), width of the bit counter (derived; not to be overridden).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- sin  input  1  serial data bit.
- sin_valid  input  1  sin carries a bit this cycle.
- sin_ready  output  1  block can accept a bit this cycle.
- msb_first  input  1  frame direction; 1 = first bit received lands in MSB, 0 = first bit received lands in LSB.
- clear  input  1  synchronous abort: discards the partial frame and clears overrun.
- dout  output  WIDTH  assembled word.
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer accepts dout this cycle.
- bit_cnt  output  CW  bits accepted in the current frame (0..WIDTH).
- overrun  output  1  sticky; a bit was offered while sin_ready was 0.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, shreg=0, bit_cnt=0, dir=1, dout=0, dout_valid=0, overrun=0. Reset asserted mid-frame or mid-stall discards everything.
- Accept: a bit is accepted on a rising edge when sin_valid && sin_ready.
- States:
  - IDLE: bit_cnt=0, sin_ready=1.
  - SHIFT: 0 < bit_cnt < WIDTH, sin_ready=1.
  - STALL: a full word is held in shreg and the output register is occupied; sin_ready=0.
- Direction latch: dir <= msb_first on the first accepted bit of a frame (bit_cnt==0). The shift for that bit uses msb_first directly. Changes to msb_first mid-frame are ignored.
- Shift rules:
  - dir=1: shreg <= {shreg[WIDTH-2:0], sin}.
  - dir=0: shreg <= {sin, shreg[WIDTH-1:1]}.
- Frame completion: on the edge accepting bit WIDTH, the next-shreg value is the complete word.
  - If !dout_valid || dout_ready: dout <= complete word, dout_valid=1, bit_cnt=0, state=IDLE. Latency is zero cycles: the word is visible on dout right after the last bit's edge.
  - Otherwise: shreg <= complete word, bit_cnt=WIDTH, state=STALL.
- STALL: on the first edge with dout_ready=1, dout <= shreg, dout_valid stays 1, shreg=0, bit_cnt=0, state=IDLE.
- Output handshake:
  - dout_valid falls on an edge with dout_ready=1 only if no new word is loaded on that edge.
  - dout holds stable while dout_valid && !dout_ready.
  - Back-to-back words with dout_ready tied high sustain one word per WIDTH accepted bits, with no bubble.
- Overrun: set on any edge with sin_valid && !sin_ready. The offered bit is dropped and shreg is unchanged. overrun stays set until clear or reset.
- clear:
  - Forces state=IDLE, shreg=0, bit_cnt=0, overrun=0.
  - Does not touch dout or dout_valid.
  - Takes priority over a simultaneous bit accept, which is discarded.
  - In STALL, the held word is discarded.
- sin_valid=0 in SHIFT: hold state; no timeout.
- Gaps between bits are allowed.

Decomposition:
- Shared package shift_link_pkg:
  - State encoding: ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_STALL=2'd2.
  - Direction constants DIR_LSB_FIRST=1'b0, DIR_MSB_FIRST=1'b1.
  - Mode constants for the matching bidirectional transmitter (HOLD=2'b00, SHIFT_R=2'b01, SHIFT_L=2'b10, LOAD=2'b11).
- One natural sub-module: shift_frame_outreg, a one-entry valid/ready output holding register. It owns dout/dout_valid, takes a load strobe and data, and returns a "can_load" signal.

Test Plan:
- Reset, then msb_first=1, bits 1,0,1,1 on consecutive cycles, dout_ready=1 -> dout=4'b1011, dout_valid=1 on the edge after the 4th bit, bit_cnt back to 0.
- msb_first=0, bits 1,0,1,1 -> dout=4'b1101. Toggling msb_first to 1 after the first bit still yields 4'b1101.
- dout_ready=0; send frame 1,1,0,0 (MSB-first) then frame 0,1,1,0 -> first dout=4'b1100 held, STALL with sin_ready=0. A 9th offered bit sets overrun=1. Raise dout_ready -> dout=4'b0110 next edge, sin_ready=1.
- Continuous stream of 8 bits 1,0,0,1,0,1,1,1 with dout_ready=1, sin_valid gapped every other cycle -> words 4'b1001 then 4'b0111, each valid exactly after its 4th bit.
- Mid-frame (bit_cnt=2) assert clear together with sin_valid -> bit_cnt=0, overrun=0, dout unchanged. Next 4 bits 0,0,0,1 (MSB-first) -> 4'b0001.
- Assert rst_n low asynchronously (between edges) during STALL -> dout=0, dout_valid=0, sin_ready=1, bit_cnt=0 immediately, without waiting for a clock edge.
